tick_gen: RTL
=============

# tick_gen

Fractional clock-enable generator for the internal clock domain produced by the PLL. It divides the fast system clock down with a phase accumulator (fractional-N). It emits single-cycle `tick` enables and a ~50% duty `clk_out` square wave for slow peripherals such as the UART baud, timers and LED PWM. The increment can be reprogrammed at runtime through a valid/ready handshake and takes effect only on a tick boundary, so peripherals never see a glitched period.

## Interface
- FREQ_MHZ, 60: system clock frequency; documentation and bench only, not used in arithmetic.
- ACC_W, 24: accumulator width in bits; range 8..32.
- INC_RESET, 279620: increment after reset. This is round(1 MHz × 2^24 / 60 MHz).
- clk  input  1  system clock (PLL output); single clock domain.
- reset  input  1  synchronous, active-high reset.
- en  input  1  accumulate enable; when 0 the phase freezes.
- phase_clr  input  1  synchronous phase zeroing; takes priority over `en`.
- cfg_valid  input  1  new increment offered.
- cfg_inc  input  ACC_W  new increment value.
- cfg_ready  output  1  block can accept a new increment.
- tick  output  1  one-cycle enable at each accumulator carry.
- clk_out  output  1  registered accumulator MSB (divided clock).
- inc_cur  output  ACC_W  increment currently in use.
- tick_cnt  output  16  free-running tick counter, wraps.

## Operation
- Registers: `acc[ACC_W-1:0]`, `inc[ACC_W-1:0]`, `pend_inc[ACC_W-1:0]`, `pend` flag, `tick`, `clk_out`, `tick_cnt`.
- Reset values: acc=0, inc=INC_RESET, pend=0, tick=0, clk_out=0, cfg_ready=1, tick_cnt=0.
- Add: `{carry, sum} = acc + inc`, computed with ACC_W+1 bits. Overflow is modulo 2^ACC_W by construction.
- Priority on each edge, highest first: reset, then phase_clr, then en, then hold.
- phase_clr=1:
  - acc←0, tick←0, clk_out←0.
  - If pend=1, inc←pend_inc and pend←0.
- en=1, phase_clr=0:
  - acc←sum, tick←carry, clk_out←sum[ACC_W-1].
- en=0, phase_clr=0:
  - acc, clk_out and inc hold; tick←0.
- tick_cnt: increments on every cycle where the registered tick is 1; 0xFFFF wraps to 0x0000.
- cfg_ready = ~pend.
- Accept: on an edge with cfg_valid & cfg_ready, pend_inc←cfg_inc and pend←1. cfg_ready is 0 from the next cycle on.
- cfg_valid while cfg_ready=0 is ignored. The offerer must hold the request until it sees ready.
- Apply pending. On an edge with pend=1 and any of the following, inc←pend_inc and pend←0:
  - en=1 and carry=1 (tick boundary);
  - phase_clr=1;
  - inc==0, so a stalled generator can be restarted.
- Acceptance and application never occur on the same edge, so a newly accepted value applies at the earliest on the next edge.
- The carry that triggers an update uses the old inc; the new inc is used from the following add.
- inc=0 is legal: acc freezes, no ticks. A later config applies on the edge after acceptance.
- inc_cur = inc, combinational from the register.
- Output frequency: f_tick = f_clk × inc / 2^ACC_W. clk_out has the same frequency, with ±1 cycle duty jitter for non-power-of-two ratios.

## Timing
- tick is registered. It is high in the cycle after the edge whose add carried, and is exactly one cycle wide unless inc ≥ 2^(ACC_W-1) causes carries on consecutive edges.
- With inc=2^ACC_W−1, tick is high on all but one cycle per 2^ACC_W; this is legal.
- Latency from reset deassertion, en=1, inc=2^k: first tick is high after the 2^(ACC_W−k)-th enabled edge.
- cfg handshake: one transfer per accept. cfg_ready returns to 1 the cycle after the apply edge.
- Reset mid-operation: pend is discarded, inc returns to INC_RESET, and the next cycle matches the reset values.
- All outputs are registered or derived directly from registers. There are no combinational input-to-output paths except cfg_ready←pend, which is registered state.

## Test plan
- Reset, en=1, cfg INC = 0x400000 (ACC_W=24) → tick high every 4th cycle. clk_out pattern is 0,1,1,0 repeating once the increment is applied. tick_cnt=25 after 100 ticks-worth of cycles.
- Default INC_RESET, 60 000 000 cycles → tick_cnt counts 1 000 000 mod 65536 = 0x4240, ±1.
- Mid-period cfg 0x800000 while acc=0x200000 → cfg_ready drops the next cycle. Old period completes unchanged, then ticks every 2 cycles. inc_cur changes on the carry edge, and cfg_ready rises on the following cycle.
- en=0 for 10 cycles mid-period → acc and clk_out hold, tick=0. Resuming continues the phase with no extra or lost tick.
- phase_clr with a pending cfg 0x100000 → acc=0, tick=0, clk_out=0, new inc applied immediately. Next tick follows 16 enabled edges later.
- cfg inc=0, then cfg 0x400000 → ticks stop, then restart with the 4-cycle pattern. Reset asserted while pend=1 → inc_cur=INC_RESET, cfg_ready=1.

Source files
------------

// File: rtl/tick_gen.sv
// Fractional-N clock-enable generator: phase accumulator producing one-cycle ticks and a
// divided square wave, with a runtime increment that only changes on a tick boundary.
module tick_gen #(
    parameter int unsigned FREQ_MHZ  = 60,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned INC_RESET = 279620
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_phase_clr,
    input  logic             i_cfg_valid,
    input  logic [ACC_W-1:0] i_cfg_inc,
    output logic             o_cfg_ready,
    output logic             o_tick,
    output logic             o_clk_out,
    output logic [ACC_W-1:0] o_inc_cur,
    output logic [15:0]      o_tick_cnt
);

    localparam logic [ACC_W-1:0] INC_RST_V = ACC_W'(INC_RESET);

    if ((ACC_W < 8) || (ACC_W > 32) || (FREQ_MHZ == 0)) begin : g_param_check
        $error("tick_gen: ACC_W must be 8..32 and FREQ_MHZ nonzero");
    end

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_pend_inc;
    logic             r_pend;
    logic             r_tick;
    logic             r_clk_out;
    logic [15:0]      r_tick_cnt;

    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic             w_apply;
    logic             w_accept;

    assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_carry = w_sum[ACC_W];

    // A zero increment never carries, so it must not block a pending update.
    assign w_apply  = r_pend & (i_phase_clr | (i_en & w_carry) | (r_inc == '0));
    assign w_accept = i_cfg_valid & ~r_pend;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc      <= '0;
            r_inc      <= INC_RST_V;
            r_pend_inc <= '0;
            r_pend     <= 1'b0;
            r_tick     <= 1'b0;
            r_clk_out  <= 1'b0;
            r_tick_cnt <= '0;
        end else begin
            if (r_tick) begin
                r_tick_cnt <= r_tick_cnt + 16'd1;
            end

            if (i_phase_clr) begin
                r_acc     <= '0;
                r_tick    <= 1'b0;
                r_clk_out <= 1'b0;
            end else if (i_en) begin
                r_acc     <= w_sum[ACC_W-1:0];
                r_tick    <= w_carry;
                r_clk_out <= w_sum[ACC_W-1];
            end else begin
                r_tick    <= 1'b0;
            end

            // Accept requires pend=0 and apply requires pend=1, so they never coincide.
            if (w_apply) begin
                r_inc  <= r_pend_inc;
                r_pend <= 1'b0;
            end else if (w_accept) begin
                r_pend_inc <= i_cfg_inc;
                r_pend     <= 1'b1;
            end
        end
    end

    assign o_cfg_ready = ~r_pend;
    assign o_tick      = r_tick;
    assign o_clk_out   = r_clk_out;
    assign o_inc_cur   = r_inc;
    assign o_tick_cnt  = r_tick_cnt;

endmodule
